// File: rtl/ysyx_210544_axi_arbiter_pkg.sv
// Shared types for the two-master AXI-side arbiter: FSM encoding and master IDs.
package ysyx_210544_axi_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_e;

  localparam logic M0_ID = 1'b0;  // I-cache
  localparam logic M1_ID = 1'b1;  // D-cache

  function automatic arb_state_e own_state(input logic id);
    return id ? OWN1 : OWN0;
  endfunction

endpackage

// File: rtl/ysyx_210544_rr_pick2.sv
// Two-requester pick: a lone requester wins, a tie goes to the rr-preferred master.
module ysyx_210544_rr_pick2 (
  input  logic [1:0] req,
  input  logic       rr,
  output logic       winner
);

  assign winner = (&req) ? rr : req[1];

endmodule

// File: rtl/ysyx_210544_axi_arbiter.sv
// Grants the single downstream AXI port to the I-cache or D-cache; a grant is held
// for as long as the owner keeps valid high so multi-beat line fills stay atomic.
module ysyx_210544_axi_arbiter #(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned DATA_W = 512
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              i_m0_valid,
  output logic              o_m0_ready,
  input  logic              i_m0_op,
  input  logic [ADDR_W-1:0] i_m0_addr,
  input  logic [DATA_W-1:0] i_m0_wdata,
  input  logic [1:0]        i_m0_size,
  input  logic [7:0]        i_m0_blks,
  output logic [DATA_W-1:0] o_m0_rdata,

  input  logic              i_m1_valid,
  output logic              o_m1_ready,
  input  logic              i_m1_op,
  input  logic [ADDR_W-1:0] i_m1_addr,
  input  logic [DATA_W-1:0] i_m1_wdata,
  input  logic [1:0]        i_m1_size,
  input  logic [7:0]        i_m1_blks,
  output logic [DATA_W-1:0] o_m1_rdata,

  output logic              o_axi_io_valid,
  input  logic              i_axi_io_ready,
  output logic              o_axi_io_op,
  output logic [ADDR_W-1:0] o_axi_io_addr,
  output logic [DATA_W-1:0] o_axi_io_wdata,
  output logic [1:0]        o_axi_io_size,
  output logic [7:0]        o_axi_io_blks,
  input  logic [DATA_W-1:0] i_axi_io_rdata,

  output logic              o_busy,
  output logic              o_owner
);

  import ysyx_210544_axi_arbiter_pkg::*;

  arb_state_e state;
  logic       rr;
  logic [1:0] req;
  logic       hold;
  logic       winner;
  logic       own0;
  logic       own1;

  // Masters eligible for a new grant; the current owner is masked so a release hands over directly.
  always_comb begin
    req  = 2'b00;
    hold = 1'b0;
    case (state)
      IDLE: req = {i_m1_valid, i_m0_valid};
      OWN0: begin
        hold = i_m0_valid;
        req  = {i_m1_valid, 1'b0};
      end
      OWN1: begin
        hold = i_m1_valid;
        req  = {1'b0, i_m0_valid};
      end
      default: ;
    endcase
  end

  ysyx_210544_rr_pick2 u_pick (
    .req    (req),
    .rr     (rr),
    .winner (winner)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      rr    <= M1_ID;
    end else if (!hold) begin
      if (|req) begin
        state <= own_state(winner);
        rr    <= ~winner;
      end else begin
        state <= IDLE;
      end
    end
  end

  assign own0 = (state == OWN0);
  assign own1 = (state == OWN1);

  // Owner's request fields drive downstream; zero when nobody holds the grant.
  always_comb begin
    o_axi_io_op    = 1'b0;
    o_axi_io_addr  = '0;
    o_axi_io_wdata = '0;
    o_axi_io_size  = 2'b00;
    o_axi_io_blks  = 8'h00;
    if (own0) begin
      o_axi_io_op    = i_m0_op;
      o_axi_io_addr  = i_m0_addr;
      o_axi_io_wdata = i_m0_wdata;
      o_axi_io_size  = i_m0_size;
      o_axi_io_blks  = i_m0_blks;
    end else if (own1) begin
      o_axi_io_op    = i_m1_op;
      o_axi_io_addr  = i_m1_addr;
      o_axi_io_wdata = i_m1_wdata;
      o_axi_io_size  = i_m1_size;
      o_axi_io_blks  = i_m1_blks;
    end
  end

  assign o_axi_io_valid = (own0 & i_m0_valid) | (own1 & i_m1_valid);
  assign o_m0_ready     = own0 & i_axi_io_ready & i_m0_valid;
  assign o_m1_ready     = own1 & i_axi_io_ready & i_m1_valid;

  // Read data is broadcast; held at zero while reset is asserted.
  assign o_m0_rdata = {DATA_W{rst}} & i_axi_io_rdata;
  assign o_m1_rdata = {DATA_W{rst}} & i_axi_io_rdata;

  assign o_busy  = (state != IDLE);
  assign o_owner = own1 ? M1_ID : M0_ID;

endmodule

// File: tb/tb_ysyx_210544_axi_arbiter.sv
// Self-checking bench for ysyx_210544_axi_arbiter: directed scenarios plus random traffic
// compared every cycle against a grant/round-robin reference model.
module tb_ysyx_210544_axi_arbiter;

  localparam int unsigned ADDR_W = 64;
  localparam int unsigned DATA_W = 512;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic              i_m0_valid, i_m0_op, i_m1_valid, i_m1_op, i_axi_io_ready;
  logic [ADDR_W-1:0] i_m0_addr, i_m1_addr;
  logic [DATA_W-1:0] i_m0_wdata, i_m1_wdata, i_axi_io_rdata;
  logic [1:0]        i_m0_size, i_m1_size;
  logic [7:0]        i_m0_blks, i_m1_blks;
  logic              o_m0_ready, o_m1_ready, o_axi_io_valid, o_axi_io_op, o_busy, o_owner;
  logic [ADDR_W-1:0] o_axi_io_addr;
  logic [DATA_W-1:0] o_m0_rdata, o_m1_rdata, o_axi_io_wdata;
  logic [1:0]        o_axi_io_size;
  logic [7:0]        o_axi_io_blks;

  ysyx_210544_axi_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst),
    .i_m0_valid(i_m0_valid), .o_m0_ready(o_m0_ready), .i_m0_op(i_m0_op), .i_m0_addr(i_m0_addr),
    .i_m0_wdata(i_m0_wdata), .i_m0_size(i_m0_size), .i_m0_blks(i_m0_blks), .o_m0_rdata(o_m0_rdata),
    .i_m1_valid(i_m1_valid), .o_m1_ready(o_m1_ready), .i_m1_op(i_m1_op), .i_m1_addr(i_m1_addr),
    .i_m1_wdata(i_m1_wdata), .i_m1_size(i_m1_size), .i_m1_blks(i_m1_blks), .o_m1_rdata(o_m1_rdata),
    .o_axi_io_valid(o_axi_io_valid), .i_axi_io_ready(i_axi_io_ready), .o_axi_io_op(o_axi_io_op),
    .o_axi_io_addr(o_axi_io_addr), .o_axi_io_wdata(o_axi_io_wdata), .o_axi_io_size(o_axi_io_size),
    .o_axi_io_blks(o_axi_io_blks), .i_axi_io_rdata(i_axi_io_rdata),
    .o_busy(o_busy), .o_owner(o_owner)
  );

  typedef struct packed {
    logic              valid;
    logic              op;
    logic [ADDR_W-1:0] addr;
    logic [1:0]        size;
    logic [7:0]        blks;
    logic              r0;
    logic              r1;
    logic              busy;
    logic              owner;
  } ctrl_t;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: current owner (-1 none) and the master preferred on a tie.
  int m_own = -1;
  int m_rr  = 1;

  ctrl_t o_ctrl, e_ctrl;
  logic [3*DATA_W-1:0] o_dat, e_dat;

  function automatic logic [DATA_W-1:0] rand_line();
    logic [DATA_W-1:0] l;
    for (int i = 0; i < int'(DATA_W / 32); i++) l[i*32 +: 32] = $urandom();
    return l;
  endfunction

  task automatic rand_fields();
    i_m0_op = 1'($urandom_range(0, 1));  i_m1_op = 1'($urandom_range(0, 1));
    i_m0_addr = {$urandom(), $urandom()}; i_m1_addr = {$urandom(), $urandom()};
    i_m0_wdata = rand_line();              i_m1_wdata = rand_line();
    i_m0_size = 2'($urandom_range(0, 3));  i_m1_size = 2'($urandom_range(0, 3));
    i_m0_blks = 8'($urandom());            i_m1_blks = 8'($urandom());
    i_axi_io_rdata = rand_line();
  endtask

  function automatic ctrl_t dut_ctrl();
    ctrl_t d;
    d.valid = o_axi_io_valid; d.op = o_axi_io_op; d.addr = o_axi_io_addr;
    d.size = o_axi_io_size; d.blks = o_axi_io_blks; d.r0 = o_m0_ready; d.r1 = o_m1_ready;
    d.busy = o_busy; d.owner = o_owner;
    return d;
  endfunction

  function automatic logic [3*DATA_W-1:0] dut_data();
    return {o_axi_io_wdata, o_m0_rdata, o_m1_rdata};
  endfunction

  function automatic ctrl_t exp_ctrl();
    ctrl_t e;
    e = '0;
    if (rst && m_own == 0) begin
      e.busy = 1'b1; e.valid = i_m0_valid; e.op = i_m0_op; e.addr = i_m0_addr;
      e.size = i_m0_size; e.blks = i_m0_blks; e.r0 = i_axi_io_ready & i_m0_valid;
    end else if (rst && m_own == 1) begin
      e.busy = 1'b1; e.owner = 1'b1; e.valid = i_m1_valid; e.op = i_m1_op; e.addr = i_m1_addr;
      e.size = i_m1_size; e.blks = i_m1_blks; e.r1 = i_axi_io_ready & i_m1_valid;
    end
    return e;
  endfunction

  function automatic logic [3*DATA_W-1:0] exp_data();
    logic [DATA_W-1:0] wd, rd;
    wd = '0;
    if (rst && m_own == 0) wd = i_m0_wdata;
    else if (rst && m_own == 1) wd = i_m1_wdata;
    rd = rst ? i_axi_io_rdata : '0;
    return {wd, rd, rd};
  endfunction

  // Grant rules evaluated at a clock edge from the requests seen at that edge.
  task automatic model_edge();
    bit v[2];
    int w;
    v[0] = i_m0_valid;
    v[1] = i_m1_valid;
    if (m_own >= 0 && v[m_own]) return;
    if (m_own >= 0) begin
      w = 1 - m_own;
      if (v[w]) begin m_own = w; m_rr = 1 - w; end
      else m_own = -1;
    end else if (v[0] || v[1]) begin
      w = (v[0] && v[1]) ? m_rr : (v[1] ? 1 : 0);
      m_own = w;
      m_rr  = 1 - w;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) model_edge();
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    m_own = -1;
    m_rr  = 1;
  endtask

  task automatic test_reset();
    apply_reset();
    rand_fields();
    i_m0_valid = 1'b1; i_m1_valid = 1'b1; i_axi_io_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #3;
      o_ctrl = dut_ctrl(); e_ctrl = exp_ctrl(); vectors++;
      if (o_ctrl !== e_ctrl) begin
        miscompares++; $display("FAIL reset ctrl c%0d: got %h want %h", c, o_ctrl, e_ctrl);
      end
      o_dat = dut_data(); vectors++;
      if (o_dat !== '0) begin
        miscompares++; $display("FAIL reset data c%0d: got rd0=%h want 0", c, o_dat[DATA_W +: 32]);
      end
      tick();
    end
    i_m0_valid = 1'b0; i_m1_valid = 1'b0; i_axi_io_ready = 1'b0;
    rst = 1'b1;
    tick();
  endtask

  task automatic test_single();
    int pulses = 0;
    rand_fields();
    i_m0_op = 1'b0;
    i_m0_addr = 64'h8000_0040;
    for (int c = 0; c < 8; c++) begin
      i_m0_valid = (c <= 4);
      i_axi_io_ready = (c == 4);
      i_axi_io_rdata = rand_line();
      #3;
      o_ctrl = dut_ctrl(); e_ctrl = exp_ctrl(); vectors++;
      if (o_ctrl !== e_ctrl) begin
        miscompares++; $display("FAIL single ctrl c%0d: got %h want %h", c, o_ctrl, e_ctrl);
      end
      o_dat = dut_data(); e_dat = exp_data(); vectors++;
      if (o_dat !== e_dat) begin
        miscompares++;
        $display("FAIL single data c%0d: got rd0=%h want %h", c, o_dat[DATA_W +: 32], e_dat[DATA_W +: 32]);
      end
      if (c == 1) begin
        vectors++;
        if (o_axi_io_valid !== 1'b1 || o_axi_io_addr !== 64'h8000_0040) begin
          miscompares++;
          $display("FAIL single grant_latency: got valid=%b addr=%h want 1 80000040", o_axi_io_valid, o_axi_io_addr);
        end
      end
      if (o_m0_ready === 1'b1) pulses++;
      tick();
    end
    vectors++;
    if (pulses != 1 || o_busy !== 1'b0) begin
      miscompares++; $display("FAIL single ready_pulse: got pulses=%0d busy=%b want 1 0", pulses, o_busy);
    end
  endtask

  task automatic test_first_tie();
    bit v0_t[10] = '{1, 1, 1, 1, 0, 0, 1, 1, 0, 0};
    bit v1_t[10] = '{1, 1, 0, 0, 0, 0, 1, 1, 0, 0};
    apply_reset();
    rand_fields();
    i_axi_io_ready = 1'b1;
    #3;
    rst = 1'b1;
    i_m0_valid = 1'b1; i_m1_valid = 1'b1;
    tick();
    for (int c = 0; c < 10; c++) begin
      i_m0_valid = v0_t[c]; i_m1_valid = v1_t[c];
      #3;
      o_ctrl = dut_ctrl(); e_ctrl = exp_ctrl(); vectors++;
      if (o_ctrl !== e_ctrl) begin
        miscompares++; $display("FAIL first_tie ctrl c%0d: got %h want %h", c, o_ctrl, e_ctrl);
      end
      if (c <= 3) begin
        vectors++;
        if (o_busy !== 1'b1 || o_owner !== (c <= 2 ? 1'b1 : 1'b0)) begin
          miscompares++;
          $display("FAIL first_tie handover c%0d: got busy=%b owner=%b want 1 %b", c, o_busy, o_owner, (c <= 2));
        end
      end
      if (c == 7) begin
        vectors++;
        if (o_owner !== 1'b1) begin
          miscompares++; $display("FAIL first_tie rr_after_own0: got owner=%b want 1", o_owner);
        end
      end
      tick();
    end
  endtask

  task automatic test_flash();
    int k = 0;
    int c = 0;
    rand_fields();
    i_m0_valid = 1'b1; i_m1_valid = 1'b0;
    while (k < 16 && c < 200) begin
      i_m0_addr = 64'h3000_0000 + 64'(4 * k);
      i_m1_valid = (c >= 1);
      i_m1_addr = {$urandom(), $urandom()};
      i_axi_io_ready = 1'($urandom_range(0, 1));
      i_axi_io_rdata = rand_line();
      #3;
      o_ctrl = dut_ctrl(); e_ctrl = exp_ctrl(); vectors++;
      if (o_ctrl !== e_ctrl) begin
        miscompares++; $display("FAIL flash ctrl c%0d: got %h want %h", c, o_ctrl, e_ctrl);
      end
      vectors++;
      if (o_m1_ready !== 1'b0 || o_owner !== 1'b0) begin
        miscompares++; $display("FAIL flash atomic c%0d: got m1_ready=%b owner=%b want 0 0", c, o_m1_ready, o_owner);
      end
      if (o_m0_ready === 1'b1) k++;
      c++;
      tick();
    end
    vectors++;
    if (k != 16) begin
      miscompares++; $display("FAIL flash beats: got %0d want 16 within 200 cycles", k);
    end
    i_m0_valid = 1'b0;
    for (int j = 0; j < 3; j++) begin
      if (j == 2) i_m1_valid = 1'b0;
      #3;
      o_ctrl = dut_ctrl(); e_ctrl = exp_ctrl(); vectors++;
      if (o_ctrl !== e_ctrl) begin
        miscompares++; $display("FAIL flash release j%0d: got %h want %h", j, o_ctrl, e_ctrl);
      end
      if (j == 1) begin
        vectors++;
        if (o_owner !== 1'b1 || o_axi_io_valid !== 1'b1) begin
          miscompares++; $display("FAIL flash handoff: got owner=%b valid=%b want 1 1", o_owner, o_axi_io_valid);
        end
      end
      tick();
    end
  endtask

  task automatic test_abort();
    bit v1_t[5] = '{1, 1, 0, 0, 0};
    rand_fields();
    i_m0_valid = 1'b0; i_axi_io_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      i_m1_valid = v1_t[c];
      #3;
      o_ctrl = dut_ctrl(); e_ctrl = exp_ctrl(); vectors++;
      if (o_ctrl !== e_ctrl) begin
        miscompares++; $display("FAIL abort ctrl c%0d: got %h want %h", c, o_ctrl, e_ctrl);
      end
      vectors++;
      if (o_axi_io_valid !== (c == 1) || o_busy !== (c == 1 || c == 2)) begin
        miscompares++;
        $display("FAIL abort track c%0d: got valid=%b busy=%b want %b %b", c, o_axi_io_valid, o_busy, (c == 1), (c == 1 || c == 2));
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    rand_fields();
    i_m0_valid = 1'b1; i_m1_valid = 1'b0; i_axi_io_ready = 1'b0;
    tick();
    #3;
    vectors++;
    if (o_axi_io_valid !== 1'b1 || o_owner !== 1'b0) begin
      miscompares++; $display("FAIL reset_mid grant: got valid=%b owner=%b want 1 0", o_axi_io_valid, o_owner);
    end
    apply_reset();
    #1;
    vectors++;
    if (o_axi_io_valid !== 1'b0 || o_busy !== 1'b0 || o_m0_rdata !== '0) begin
      miscompares++; $display("FAIL reset_mid async: got valid=%b busy=%b want 0 0", o_axi_io_valid, o_busy);
    end
    #1;
    i_m1_valid = 1'b1;
    rst = 1'b1;
    tick();
    #3;
    o_ctrl = dut_ctrl(); e_ctrl = exp_ctrl(); vectors++;
    if (o_ctrl !== e_ctrl || o_owner !== 1'b1) begin
      miscompares++; $display("FAIL reset_mid tie: got %h want %h", o_ctrl, e_ctrl);
    end
    i_m0_valid = 1'b0; i_m1_valid = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_fairness();
    int n0 = 0, n1 = 0, last = -1, alt_err = 0, c = 0;
    bit hs0 = 0, hs1 = 0;
    i_axi_io_ready = 1'b1;
    while ((n0 + n1) < 100 && c < 600) begin
      rand_fields();
      i_m0_valid = !hs0;
      i_m1_valid = !hs1;
      #3;
      o_ctrl = dut_ctrl(); e_ctrl = exp_ctrl(); vectors++;
      if (o_ctrl !== e_ctrl) begin
        miscompares++; $display("FAIL fairness ctrl c%0d: got %h want %h", c, o_ctrl, e_ctrl);
      end
      hs0 = (o_m0_ready === 1'b1);
      hs1 = (o_m1_ready === 1'b1);
      if (hs0) begin n0++; if (last == 0) alt_err++; last = 0; end
      if (hs1) begin n1++; if (last == 1) alt_err++; last = 1; end
      c++;
      tick();
    end
    vectors++;
    if (n0 != 50 || n1 != 50 || alt_err != 0) begin
      miscompares++; $display("FAIL fairness split: got m0=%0d m1=%0d repeats=%0d want 50 50 0", n0, n1, alt_err);
    end
    i_m0_valid = 1'b0; i_m1_valid = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      rand_fields();
      if (i_m0_valid) i_m0_valid = ($urandom_range(0, 3) != 0);
      else            i_m0_valid = ($urandom_range(0, 2) == 0);
      if (i_m1_valid) i_m1_valid = ($urandom_range(0, 3) != 0);
      else            i_m1_valid = ($urandom_range(0, 2) == 0);
      i_axi_io_ready = 1'($urandom_range(0, 1));
      #3;
      o_ctrl = dut_ctrl(); e_ctrl = exp_ctrl(); vectors++;
      if (o_ctrl !== e_ctrl) begin
        miscompares++; $display("FAIL random ctrl c%0d: got %h want %h", c, o_ctrl, e_ctrl);
      end
      o_dat = dut_data(); e_dat = exp_data(); vectors++;
      if (o_dat !== e_dat) begin
        miscompares++;
        $display("FAIL random data c%0d: got wd=%h rd1=%h want %h %h", c, o_dat[2*DATA_W +: 32], o_dat[0 +: 32], e_dat[2*DATA_W +: 32], e_dat[0 +: 32]);
      end
      tick();
    end
  endtask

  initial begin
    i_m0_valid = 1'b0; i_m1_valid = 1'b0; i_axi_io_ready = 1'b0;
    rand_fields();
    test_reset();
    test_single();
    test_first_tie();
    test_flash();
    test_abort();
    test_reset_mid();
    test_fairness();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
